// File: rtl/frota_inimigos.sv
// frota_inimigos: a row of N_INIMIGOS square enemies that marches
// horizontally, steps down at the screen edge and can be shot by the
// allied ball.
//
// Ports:
//   CLOCK_50        system clock (single domain)
//   reset           asynchronous active-high reset
//   pausa           freezes every register; acerto is forced low
//   reiniciarJogo   synchronous restart to reset values (beats pausa)
//   x/y_bola_aliada allied shot centre
//   bola_ativa      allied shot in flight
//   x_frota/y_frota top-left corner of enemy 0
//   vivos           alive mask, bit i = enemy i
//   acerto          one-cycle pulse on a kill
//   indice_acerto   index of the most recently killed enemy
//   pontos          score, +10 per kill, saturating
//   onda            wave number (wraps)
//   onda_limpa      high while every enemy of the wave is dead
//   invasao         sticky: formation reached the bottom limit
module frota_inimigos #(
  parameter int unsigned N_INIMIGOS = 4,
  parameter int unsigned LARGURA    = 10,
  parameter int unsigned PERIODO    = 833333,
  parameter int unsigned XI         = 20,
  parameter int unsigned YI         = 40,
  parameter int unsigned ESPACO     = 60,
  parameter int unsigned TAM        = 45,
  parameter int unsigned PASSO_X    = 2,
  parameter int unsigned DESCIDA    = 20,
  parameter int unsigned X_MAX      = 640,
  parameter int unsigned Y_LIMITE   = 440
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  pausa,
  input  logic                  reiniciarJogo,
  input  logic [LARGURA-1:0]    x_bola_aliada,
  input  logic [LARGURA-1:0]    y_bola_aliada,
  input  logic                  bola_ativa,
  output logic [LARGURA-1:0]    x_frota,
  output logic [LARGURA-1:0]    y_frota,
  output logic [N_INIMIGOS-1:0] vivos,
  output logic                  acerto,
  output logic [3:0]            indice_acerto,
  output logic [15:0]           pontos,
  output logic [7:0]            onda,
  output logic                  onda_limpa,
  output logic                  invasao
);

  localparam int unsigned CW         = (PERIODO > 1) ? $clog2(PERIODO) : 1;
  localparam int unsigned LARG_FROTA = (N_INIMIGOS - 1) * ESPACO + TAM;

  typedef enum logic [1:0] {DIREITA, ESQUERDA, DESCE, LIMPA} estado_t;

  estado_t estado, estado_n;
  estado_t dir_desce, dir_desce_n;   // direction to resume after a descent

  logic [CW-1:0]         cnt, cnt_n;
  logic                  tick;
  logic [LARGURA-1:0]    x_n, y_n;
  logic [N_INIMIGOS-1:0] vivos_n, alvo, mata;
  logic                  acerto_n, acha, bloqueio, inv_n;
  logic [3:0]            idx, idx_n;
  logic [15:0]           pontos_n;
  logic [7:0]            onda_n;
  logic [31:0]           xb, yb, xf, yf;

  assign tick = (cnt == CW'(PERIODO - 1));
  assign xb   = 32'(x_bola_aliada);
  assign yb   = 32'(y_bola_aliada);
  assign xf   = 32'(x_frota);
  assign yf   = 32'(y_frota);

  assign onda_limpa = (estado == LIMPA);

  // Once the formation touches the bottom, movement and collisions stop
  // in that same cycle; the registered flag keeps it stopped afterwards.
  assign bloqueio = invasao || ((yf + TAM >= Y_LIMITE) && (|vivos));

  // Shot-vs-enemy test; only the lowest-index enemy hit is killed.
  always_comb begin
    alvo = '0;
    mata = '0;
    acha = 1'b0;
    idx  = '0;
    for (int unsigned i = 0; i < N_INIMIGOS; i++) begin
      alvo[i] = vivos[i] && bola_ativa &&
                (xb >= xf + i * ESPACO) && (xb < xf + i * ESPACO + TAM) &&
                (yb >= yf) && (yb < yf + TAM);
      if (alvo[i] && !acha) begin
        acha    = 1'b1;
        idx     = 4'(i);
        mata[i] = 1'b1;
      end
    end
  end

  always_comb begin
    estado_n    = estado;
    dir_desce_n = dir_desce;
    x_n         = x_frota;
    y_n         = y_frota;
    vivos_n     = vivos;
    pontos_n    = pontos;
    onda_n      = onda;
    acerto_n    = 1'b0;
    idx_n       = indice_acerto;
    cnt_n       = tick ? '0 : cnt + CW'(1);
    inv_n       = bloqueio;

    if (!bloqueio) begin
      if (acha) begin
        vivos_n  = vivos & ~mata;
        acerto_n = 1'b1;
        idx_n    = idx;
        pontos_n = (pontos > 16'd65525) ? 16'hFFFF : pontos + 16'd10;
      end

      if (tick) begin
        case (estado)
          DIREITA: begin
            if (xf + PASSO_X + LARG_FROTA > X_MAX) begin
              estado_n    = DESCE;
              dir_desce_n = ESQUERDA;
            end else begin
              x_n = x_frota + LARGURA'(PASSO_X);
            end
          end
          ESQUERDA: begin
            if (xf < PASSO_X) begin
              estado_n    = DESCE;
              dir_desce_n = DIREITA;
            end else begin
              x_n = x_frota - LARGURA'(PASSO_X);
            end
          end
          DESCE: begin
            y_n      = y_frota + LARGURA'(DESCIDA);
            estado_n = dir_desce;
          end
          LIMPA: begin
            vivos_n     = '1;
            x_n         = LARGURA'(XI);
            y_n         = LARGURA'(YI);
            onda_n      = onda + 8'd1;
            estado_n    = DIREITA;
            dir_desce_n = DIREITA;
          end
          default: estado_n = DIREITA;
        endcase
      end

      // A kill that empties the row wins over whatever the tick chose;
      // any movement from that same tick still lands.
      if (vivos_n == '0) estado_n = LIMPA;
    end

    if (reiniciarJogo) begin
      estado_n    = DIREITA;
      dir_desce_n = DIREITA;
      x_n         = LARGURA'(XI);
      y_n         = LARGURA'(YI);
      vivos_n     = '1;
      pontos_n    = '0;
      onda_n      = '0;
      acerto_n    = 1'b0;
      idx_n       = '0;
      inv_n       = 1'b0;
      cnt_n       = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      estado        <= DIREITA;
      dir_desce     <= DIREITA;
      x_frota       <= LARGURA'(XI);
      y_frota       <= LARGURA'(YI);
      vivos         <= '1;
      pontos        <= '0;
      onda          <= '0;
      acerto        <= 1'b0;
      indice_acerto <= '0;
      invasao       <= 1'b0;
      cnt           <= '0;
    end else if (reiniciarJogo || !pausa) begin
      estado        <= estado_n;
      dir_desce     <= dir_desce_n;
      x_frota       <= x_n;
      y_frota       <= y_n;
      vivos         <= vivos_n;
      pontos        <= pontos_n;
      onda          <= onda_n;
      acerto        <= acerto_n;
      indice_acerto <= idx_n;
      invasao       <= inv_n;
      cnt           <= cnt_n;
    end else begin
      acerto <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frota_inimigos.sv
module tb_frota_inimigos;

  localparam int N    = 4;
  localparam int PER  = 4;
  localparam int XI   = 20;
  localparam int YI   = 40;
  localparam int ESP  = 60;
  localparam int TAM  = 45;
  localparam int PX   = 2;
  localparam int DES  = 20;
  localparam int XMAX = 640;
  localparam int YLIM = 440;
  localparam int W    = (N - 1) * ESP + TAM;

  logic       clk = 1'b0;
  logic       reset = 1'b1, pausa = 1'b0, reiniciarJogo = 1'b0, bola_ativa = 1'b0;
  logic [9:0] x_bola = '0, y_bola = '0;
  logic [9:0] x_frota, y_frota;
  logic [3:0] vivos, indice_acerto;
  logic       acerto, onda_limpa, invasao;
  logic [15:0] pontos;
  logic [7:0] onda;

  frota_inimigos #(.N_INIMIGOS(N), .PERIODO(PER)) dut (
    .CLOCK_50(clk), .reset(reset), .pausa(pausa), .reiniciarJogo(reiniciarJogo),
    .x_bola_aliada(x_bola), .y_bola_aliada(y_bola), .bola_ativa(bola_ativa),
    .x_frota(x_frota), .y_frota(y_frota), .vivos(vivos), .acerto(acerto),
    .indice_acerto(indice_acerto), .pontos(pontos), .onda(onda),
    .onda_limpa(onda_limpa), .invasao(invasao)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x, y, viv, ac, pts, onda, limpa, inv;
  } exp_t;

  exp_t exp_q[$];
  int   hit_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: formation described by position, per-enemy alive
  // flags and a movement mode (0 right, 1 left, 2 stepping down, 3 cleared).
  int m_x, m_y, m_pts, m_onda, m_cnt, m_mode, m_after;
  bit m_alive[N];
  bit m_ac, m_inv;

  function automatic int alive_mask();
    int v = 0;
    for (int i = 0; i < N; i++) if (m_alive[i]) v |= (1 << i);
    return v;
  endfunction

  task automatic model_reset();
    m_x = XI; m_y = YI; m_pts = 0; m_onda = 0; m_cnt = 0;
    m_mode = 0; m_after = 0; m_ac = 0; m_inv = 0;
    for (int i = 0; i < N; i++) m_alive[i] = 1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step(input bit r, input bit p, input bit rj, input bit ba,
                      input int bx, input int by);
    bit   tick, blocked, killed;
    exp_t e;
    if (r || rj) begin
      model_reset();
    end else if (p) begin
      m_ac = 0;
    end else begin
      tick    = (m_cnt == PER - 1);
      m_cnt   = tick ? 0 : m_cnt + 1;
      m_ac    = 0;
      blocked = m_inv || ((m_y + TAM >= YLIM) && alive_mask() != 0);
      m_inv   = blocked;
      if (!blocked) begin
        killed = 0;
        if (ba)
          for (int i = 0; i < N; i++)
            if (!killed && m_alive[i] &&
                bx >= m_x + i * ESP && bx < m_x + i * ESP + TAM &&
                by >= m_y && by < m_y + TAM) begin
              killed     = 1;
              m_alive[i] = 0;
              m_ac       = 1;
              m_pts      = (m_pts + 10 > 65535) ? 65535 : m_pts + 10;
              hit_q.push_back(i);
            end
        if (tick) begin
          if (m_mode == 0) begin
            if (m_x + PX + W > XMAX) begin m_mode = 2; m_after = 1; end
            else m_x += PX;
          end else if (m_mode == 1) begin
            if (m_x < PX) begin m_mode = 2; m_after = 0; end
            else m_x -= PX;
          end else if (m_mode == 2) begin
            m_y += DES;
            m_mode = m_after;
          end else begin
            for (int i = 0; i < N; i++) m_alive[i] = 1;
            m_x = XI; m_y = YI; m_onda = (m_onda + 1) % 256; m_mode = 0;
          end
        end
        if (alive_mask() == 0) m_mode = 3;
      end
    end
    e.x = m_x; e.y = m_y; e.viv = alive_mask(); e.ac = m_ac; e.pts = m_pts;
    e.onda = m_onda; e.limpa = (m_mode == 3); e.inv = m_inv;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit p, input bit rj, input bit ba,
                     input int bx, input int by);
    int cx, cy;
    cx = (bx < 0) ? 0 : (bx > 1023 ? 1023 : bx);
    cy = (by < 0) ? 0 : (by > 1023 ? 1023 : by);
    @(negedge clk);
    reset = r; pausa = p; reiniciarJogo = rj; bola_ativa = ba;
    x_bola = 10'(cx); y_bola = 10'(cy);
    step(r, p, rj, ba, cx, cy);
  endtask

  // Monitor: one expected snapshot per clock edge, plus the kill queue
  // consumed whenever the DUT raises acerto.
  always begin
    exp_t e;
    int   hi;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("x_frota", int'(x_frota), e.x);
      chk("y_frota", int'(y_frota), e.y);
      chk("vivos", int'(vivos), e.viv);
      chk("acerto", int'(acerto), e.ac);
      chk("pontos", int'(pontos), e.pts);
      chk("onda", int'(onda), e.onda);
      chk("onda_limpa", int'(onda_limpa), e.limpa);
      chk("invasao", int'(invasao), e.inv);
      if (acerto) begin
        if (hit_q.size() == 0) chk("acerto_unexpected", 1, 0);
        else begin
          hi = hit_q.pop_front();
          chk("indice_acerto", int'(indice_acerto), hi);
        end
      end
    end
  end

  initial begin
    int u, pburst, bx, by, budget;
    bit r, p, rj, ba;
    model_reset();
    pburst = 0;

    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    repeat (8) cyc(0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("boot_x", int'(x_frota), 24);
    chk("boot_y", int'(y_frota), 40);
    chk("boot_vivos", int'(vivos), 15);

    repeat (3) cyc(0, 0, 0, 1, 90, 50);
    cyc(0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("shot_vivos", int'(vivos), 13);
    chk("shot_pontos", int'(pontos), 10);

    // Paused shot on enemy 0, then release, then clear the wave.
    cyc(0, 0, 1, 0, 0, 0);
    repeat (20) cyc(0, 1, 0, 1, 30, 50);
    repeat (2) cyc(0, 0, 0, 1, 30, 50);
    for (int e = 1; e < N; e++) cyc(0, 0, 0, 1, m_x + e * ESP + 10, m_y + 10);
    repeat (10) cyc(0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("wave_onda", int'(onda), 1);
    chk("wave_pontos", int'(pontos), 40);
    chk("wave_vivos", int'(vivos), 15);

    for (int k = 0; k < 4000; k++) begin
      u  = $urandom_range(0, 999);
      r  = (u < 2);
      rj = (u >= 2 && u < 5);
      if (pburst > 0) begin p = 1; pburst--; end
      else begin
        p = 0;
        if ($urandom_range(0, 99) < 3) pburst = $urandom_range(1, 15);
      end
      ba = ($urandom_range(0, 99) < 30);
      bx = m_x + int'($urandom_range(0, W + 10)) - 5;
      by = m_y + int'($urandom_range(0, TAM + 15)) - 5;
      cyc(r, p, rj, ba, bx, by);
    end

    // March undisturbed until the formation reaches the bottom.
    cyc(0, 0, 1, 0, 0, 0);
    budget = 0;
    while (!m_inv && budget < 20000) begin
      cyc(0, 0, 0, 0, 0, 0);
      budget++;
    end
    repeat (20) cyc(0, 0, 0, 1, m_x + 10, m_y + 10);
    @(posedge clk); #2;
    chk("invasao_sticky", int'(invasao), 1);
    chk("invasao_y", int'(y_frota), 400);

    cyc(0, 0, 1, 0, 0, 0);
    @(posedge clk); #2;
    chk("restart_invasao", int'(invasao), 0);
    chk("restart_x", int'(x_frota), XI);
    chk("restart_y", int'(y_frota), YI);
    chk("restart_pontos", int'(pontos), 0);
    repeat (10) cyc(0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("kills_drained", hit_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
